// File: rtl/sdp_bram_arbiter_if.sv
// Requester-side bus of the dual-port BRAM arbiter.
// Bit/slice i of every vector belongs to requester i (i = 0, 1).
//   req_valid/req_ready : per-requester handshake; transfer on valid & ready
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata/req_be : packed per-requester address, data, byte enables
//   rsp_valid           : one-hot read-return strobe; rsp_data is shared
// modport slave  : arbiter side
// modport master : requester side
interface sdp_bram_arbiter_if #(
  parameter int NB_COL    = 8,
  parameter int COL_WIDTH = 8,
  parameter int ADDR_W    = 9
);
  localparam int DW = NB_COL * COL_WIDTH;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DW-1:0]     req_wdata;
  logic [2*NB_COL-1:0] req_be;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sdp_bram_arbiter.sv
// Two-requester arbiter in front of a simple-dual-port BRAM (port A write,
// port B read, 2-cycle registered read). Writes and reads are arbitrated
// independently with a round-robin pointer per type, so one write and one
// read can be accepted in the same cycle.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   bus         : requester bus (sdp_bram_arbiter_if.slave)
//   bram_addra/bram_dina/bram_wea          : BRAM write port
//   bram_addrb/bram_enb/bram_rstb/bram_regceb : BRAM read port controls
//   bram_doutb  : BRAM registered read data
//   busy        : a read is accepted this cycle or still in flight
module sdp_bram_arbiter #(
  parameter int NB_COL    = 8,
  parameter int COL_WIDTH = 8,
  parameter int ADDR_W    = 9,
  localparam int DW       = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  sdp_bram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DW-1:0]     bram_dina,
  output logic [NB_COL-1:0] bram_wea,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_enb,
  output logic              bram_rstb,
  output logic              bram_regceb,
  input  logic [DW-1:0]     bram_doutb,
  output logic              busy
);

  logic [1:0]        wr_req, rd_req, wr_gnt, rd_gnt;
  logic              wr_pri, rd_pri;
  logic              wr_any, rd_any, wr_sel, rd_sel;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
  logic [DW-1:0]     wr_data_sel;
  logic [NB_COL-1:0] wr_be_sel;
  // read pipeline: stage 0 = address cycle, stage 2 = data on bram_doutb
  logic [2:0]        rd_v, rd_id;

  always_comb begin
    wr_req = '0;
    rd_req = '0;
    if (!rst) begin
      wr_req = bus.req_valid & bus.req_we;
      rd_req = bus.req_valid & ~bus.req_we;
    end
    wr_gnt = wr_req;
    if (wr_req == 2'b11) wr_gnt = wr_pri ? 2'b10 : 2'b01;
    rd_gnt = rd_req;
    if (rd_req == 2'b11) rd_gnt = rd_pri ? 2'b10 : 2'b01;
  end

  assign bus.req_ready = wr_gnt | rd_gnt;
  assign wr_any = |wr_gnt;
  assign rd_any = |rd_gnt;
  assign wr_sel = wr_gnt[1];
  assign rd_sel = rd_gnt[1];

  assign wr_addr_sel = wr_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign rd_addr_sel = rd_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign wr_data_sel = wr_sel ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
  assign wr_be_sel   = wr_sel ? bus.req_be[2*NB_COL-1:NB_COL] : bus.req_be[NB_COL-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pri     <= 1'b0;
      rd_pri     <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
      bram_wea   <= '0;
      bram_addrb <= '0;
      rd_v       <= '0;
      rd_id      <= '0;
    end else begin
      if (wr_any) begin
        wr_pri     <= ~wr_sel;
        bram_addra <= wr_addr_sel;
        bram_dina  <= wr_data_sel;
      end
      bram_wea <= wr_any ? wr_be_sel : '0;
      if (rd_any) begin
        rd_pri     <= ~rd_sel;
        bram_addrb <= rd_addr_sel;
      end
      rd_v  <= {rd_v[1:0], rd_any};
      rd_id <= {rd_id[1:0], rd_sel};
    end
  end

  assign bram_enb      = rd_v[0];
  assign bram_regceb   = ~rst;
  assign bram_rstb     = rst;
  assign bus.rsp_valid = rd_v[2] ? (rd_id[2] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = bram_doutb;
  assign busy          = (|rd_v) | rd_any;

endmodule

// File: tb/tb_sdp_bram_arbiter.sv
// Directed bench for sdp_bram_arbiter with a read-first 2-cycle BRAM model.
module tb_sdp_bram_arbiter;
  localparam int NB_COL = 8, COL_WIDTH = 8, ADDR_W = 9, DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  logic [ADDR_W-1:0] bram_addra, bram_addrb;
  logic [DW-1:0]     bram_dina, bram_doutb, rd_lat;
  logic [NB_COL-1:0] bram_wea;
  logic bram_enb, bram_rstb, bram_regceb, busy;
  logic [DW-1:0] mem [0:511];
  int n_tests = 0;
  int n_fail  = 0;

  sdp_bram_arbiter_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)) bus ();

  sdp_bram_arbiter #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_addrb(bram_addrb), .bram_enb(bram_enb), .bram_rstb(bram_rstb),
    .bram_regceb(bram_regceb), .bram_doutb(bram_doutb), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM: port A byte-write, port B read-first with output register
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 512; a++) mem[a] <= '0;
      rd_lat <= '0;
    end else begin
      for (int b = 0; b < NB_COL; b++)
        if (bram_wea[b]) mem[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
      if (bram_enb) rd_lat <= mem[bram_addrb];
    end
    if (bram_rstb) bram_doutb <= '0;
    else if (bram_regceb) bram_doutb <= rd_lat;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_be    = '0;
  endtask

  task automatic drive(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DW-1:0] data, input logic [NB_COL-1:0] be);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p]    = we;
    bus.req_addr[p*ADDR_W +: ADDR_W] = addr;
    bus.req_wdata[p*DW +: DW]        = data;
    bus.req_be[p*NB_COL +: NB_COL]   = be;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    idle();
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    repeat (3) cyc();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_wea", bram_wea, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bram_rstb", bram_rstb, 1);
    chk("rst_regceb", bram_regceb, 0);
    idle();
    rst = 1'b0;
    mem_clr = 1'b0;
    #1;
    chk("regceb_run", bram_regceb, 1);
    chk("bram_rstb_run", bram_rstb, 0);

    // both ports write: p0 first, p1 next cycle
    drive(0, 1'b1, 9'd5, 64'h1111_1111_1111_1111, 8'hFF);
    drive(1, 1'b1, 9'd6, 64'h2222_2222_2222_2222, 8'hFF);
    #1;
    chk("ww_ready_n", bus.req_ready, 2'b01);
    chk("ww_wea_n", bram_wea, 0);
    cyc();
    bus.req_valid[0] = 1'b0;
    #1;
    chk("ww_ready_n1", bus.req_ready, 2'b10);
    chk("ww_wea_n1", bram_wea, 8'hFF);
    chk("ww_addra_n1", bram_addra, 5);
    chk("ww_dina_n1", bram_dina, 64'h1111_1111_1111_1111);
    cyc();
    idle();
    #1;
    chk("ww_wea_n2", bram_wea, 8'hFF);
    chk("ww_addra_n2", bram_addra, 6);
    chk("ww_dina_n2", bram_dina, 64'h2222_2222_2222_2222);
    cyc();
    chk("ww_wea_n3", bram_wea, 0);

    // p0 read addr 5 while p1 writes addr 7
    drive(0, 1'b0, 9'd5, '0, '0);
    drive(1, 1'b1, 9'd7, 64'h7777_7777_7777_7777, 8'hFF);
    #1;
    chk("rw_ready", bus.req_ready, 2'b11);
    chk("rw_busy_n", busy, 1);
    cyc();
    idle();
    #1;
    chk("rw_enb_n1", bram_enb, 1);
    chk("rw_addrb_n1", bram_addrb, 5);
    chk("rw_wea_n1", bram_wea, 8'hFF);
    chk("rw_addra_n1", bram_addra, 7);
    cyc();
    chk("rw_enb_n2", bram_enb, 0);
    chk("rw_rsp_n2", bus.rsp_valid, 0);
    cyc();
    chk("rw_rsp_n3", bus.rsp_valid, 2'b01);
    chk("rw_data_n3", bus.rsp_data, 64'h1111_1111_1111_1111);
    cyc();
    chk("rw_rsp_n4", bus.rsp_valid, 0);
    chk("rw_busy_n4", busy, 0);

    // same-cycle write+read of addr 3 is read-first; next-cycle read sees new data
    drive(0, 1'b0, 9'd3, '0, '0);
    drive(1, 1'b1, 9'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    #1;
    chk("rf_ready", bus.req_ready, 2'b11);
    cyc();
    idle();
    drive(0, 1'b0, 9'd3, '0, '0);
    #1;
    chk("rf_ready2", bus.req_ready, 2'b01);
    cyc();
    idle();
    cyc();
    chk("rf_rsp1", bus.rsp_valid, 2'b01);
    chk("rf_data1", bus.rsp_data, 64'h0);
    cyc();
    chk("rf_rsp2", bus.rsp_valid, 2'b01);
    chk("rf_data2", bus.rsp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    cyc();
    chk("rf_rsp3", bus.rsp_valid, 0);

    // partial write be=0x01, then be=0 write, then readback by p1
    drive(0, 1'b1, 9'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    #1;
    chk("pw_ready", bus.req_ready, 2'b01);
    cyc();
    drive(0, 1'b1, 9'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    #1;
    chk("pw_wea", bram_wea, 8'h01);
    chk("be0_ready", bus.req_ready, 2'b01);
    cyc();
    idle();
    drive(1, 1'b0, 9'd9, '0, '0);
    #1;
    chk("be0_wea", bram_wea, 0);
    chk("pw_rd_ready", bus.req_ready, 2'b10);
    cyc();
    idle();
    cyc();
    cyc();
    chk("pw_rsp", bus.rsp_valid, 2'b10);
    chk("pw_data", bus.rsp_data, 64'h0000_0000_0000_00FF);
    cyc();

    // both ports read continuously for 6 cycles
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        drive(0, 1'b0, 9'd5, '0, '0);
        drive(1, 1'b0, 9'd6, '0, '0);
      end else begin
        idle();
      end
      #1;
      if (k < 6) chk($sformatf("rr_ready_%0d", k), bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k >= 3 && k < 9) begin
        chk($sformatf("rr_rsp_%0d", k), bus.rsp_valid, ((k - 3) % 2) ? 2'b10 : 2'b01);
        chk($sformatf("rr_data_%0d", k), bus.rsp_data,
            ((k - 3) % 2) ? 64'h2222_2222_2222_2222 : 64'h1111_1111_1111_1111);
      end
      if (k == 9) chk("rr_rsp_end", bus.rsp_valid, 0);
      chk($sformatf("rr_busy_%0d", k), busy, (k < 9) ? 1 : 0);
      cyc();
    end

    // reset pulsed the cycle after a read (and a write) are accepted
    drive(0, 1'b0, 9'd5, '0, '0);
    drive(1, 1'b1, 9'd12, 64'h5555_5555_5555_5555, 8'hFF);
    #1;
    chk("mr_ready", bus.req_ready, 2'b11);
    cyc();
    idle();
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    rst = 1'b1;
    #1;
    chk("mr_ready_rst", bus.req_ready, 0);
    chk("mr_wea_rst", bram_wea, 0);
    chk("mr_enb_rst", bram_enb, 0);
    chk("mr_busy_rst", busy, 0);
    chk("mr_rsp_rst", bus.rsp_valid, 0);
    chk("mr_bram_rstb", bram_rstb, 1);
    chk("mr_regceb", bram_regceb, 0);
    cyc();
    idle();
    rst = 1'b0;
    drive(0, 1'b1, 9'd20, '0, '0);
    drive(1, 1'b1, 9'd21, '0, '0);
    #1;
    chk("mr_wr_pri", bus.req_ready, 2'b01);
    bus.req_we = 2'b00;
    #1;
    chk("mr_rd_pri", bus.req_ready, 2'b01);
    idle();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("mr_no_rsp_%0d", k), bus.rsp_valid, 0);
    end
    drive(0, 1'b0, 9'd12, '0, '0);
    cyc();
    idle();
    cyc();
    cyc();
    chk("mr_cancel_rsp", bus.rsp_valid, 2'b01);
    chk("mr_cancel_data", bus.rsp_data, 64'h0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
